// File: rtl/credit_fwd_pipe.sv
// Fixed-latency valid/data delay line for the credit link forward path.
// Valid bits reset/clear synchronously; only the output data stage is reset.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module credit_fwd_pipe #(
  parameter int p1width   = 1,
  parameter int p4latency = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               V_IN,
  input  logic [p1width-1:0] D_IN,
  output logic               V_OUT,
  output logic [p1width-1:0] D_OUT
);

  for (genvar k = 0; k < p4latency; k++) begin : g_stage
    logic               vi;
    logic [p1width-1:0] di;
    logic               v;
    logic [p1width-1:0] d;

    if (k == 0) begin : g_first
      assign vi = V_IN;
      assign di = D_IN;
    end else begin : g_next
      assign vi = g_stage[k-1].v;
      assign di = g_stage[k-1].d;
    end

    always_ff @(posedge CLK) begin
      if (RST || CLR) v <= `BSV_ASSIGNMENT_DELAY 1'b0;
      else            v <= `BSV_ASSIGNMENT_DELAY vi;
    end

    // Data only advances with a valid beat, so the output holds its last value when idle.
    if (k == p4latency - 1) begin : g_out
      always_ff @(posedge CLK) begin
        if (RST)     d <= `BSV_ASSIGNMENT_DELAY '0;
        else if (vi) d <= `BSV_ASSIGNMENT_DELAY di;
      end
    end else begin : g_mid
      always_ff @(posedge CLK) begin
        if (vi) d <= `BSV_ASSIGNMENT_DELAY di;
      end
    end
  end

  assign V_OUT = g_stage[p4latency-1].v;
  assign D_OUT = g_stage[p4latency-1].d;

endmodule

// File: rtl/credit_enq_sender.sv
// Credit-tracking transmit end of a link into a remote FIFO of depth p2depth.
// FULL_N comes from the credit register only; the forward pipeline never stalls.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module credit_enq_sender #(
  parameter int p1width      = 1,
  parameter int p2depth      = 3,
  parameter int p3cntr_width = 2,
  parameter int p4latency    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic [p1width-1:0]      D_IN,
  input  logic                    ENQ,
  output logic                    FULL_N,
  output logic                    TX_VALID,
  output logic [p1width-1:0]      TX_DATA,
  input  logic                    CRED_RET,
  output logic [p3cntr_width-1:0] CREDITS,
  output logic                    IDLE,
  output logic                    ERR
);

  localparam logic [p3cntr_width-1:0] DEPTH = p3cntr_width'(p2depth);
  localparam logic [p3cntr_width-1:0] ONE   = p3cntr_width'(1);
  localparam int                      IW    = $clog2(p4latency + 1);
  localparam logic [IW-1:0]           IONE  = IW'(1);

  logic [p3cntr_width-1:0] credits;
  logic                    err;
  logic [IW-1:0]           inflight;
  logic                    acc;

  assign FULL_N  = (credits != '0);
  assign acc     = ENQ && FULL_N && !CLR;
  assign CREDITS = credits;
  assign ERR     = err;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      credits <= `BSV_ASSIGNMENT_DELAY DEPTH;
      err     <= `BSV_ASSIGNMENT_DELAY 1'b0;
    end else begin
      if (acc && !CRED_RET) begin
        credits <= `BSV_ASSIGNMENT_DELAY credits - ONE;
      end else if (!acc && CRED_RET) begin
        if (credits == DEPTH) err <= `BSV_ASSIGNMENT_DELAY 1'b1;
        else                  credits <= `BSV_ASSIGNMENT_DELAY credits + ONE;
      end
      // A credit returned this cycle cannot rescue an enqueue made without credit.
      if (ENQ && !FULL_N) err <= `BSV_ASSIGNMENT_DELAY 1'b1;
    end
  end

  // Entries held in pipeline registers; tracks the valid bits without exposing them.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      inflight <= `BSV_ASSIGNMENT_DELAY '0;
    end else begin
      case ({acc, TX_VALID})
        2'b10:   inflight <= `BSV_ASSIGNMENT_DELAY inflight + IONE;
        2'b01:   inflight <= `BSV_ASSIGNMENT_DELAY inflight - IONE;
        default: inflight <= `BSV_ASSIGNMENT_DELAY inflight;
      endcase
    end
  end

  assign IDLE = (credits == DEPTH) && (inflight == '0);

  credit_fwd_pipe #(
    .p1width  (p1width),
    .p4latency(p4latency)
  ) u_pipe (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (CLR),
    .V_IN (acc),
    .D_IN (D_IN),
    .V_OUT(TX_VALID),
    .D_OUT(TX_DATA)
  );

`ifndef BSV_NO_INITIAL_BLOCKS
  initial begin
    if (p2depth < 1 || p4latency < 1 || (2 ** p3cntr_width) <= p2depth) begin
      $display("ERROR: credit_enq_sender: %m -- bad parameters depth=%0d latency=%0d cntr_width=%0d",
               p2depth, p4latency, p3cntr_width);
      $finish;
    end
  end

  always @(posedge CLK) begin
    if (!RST && !CLR && ENQ && !FULL_N)
      $display("Warning: credit_enq_sender: %m -- Enqueuing with no credits");
  end
`endif

endmodule

// File: tb/tb_credit_enq_sender.sv
// Scoreboard bench: stimulus queues expected TX_DATA, a negedge monitor pops on TX_VALID.
module tb_credit_enq_sender;

  logic       clk = 1'b0;
  logic       rst, clr, enq, cred_ret;
  logic [7:0] d_in;
  logic       full_n, tx_valid, idle, err;
  logic [7:0] tx_data;
  logic [1:0] credits;

  int checks   = 0;
  int failures = 0;
  int tx_count = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  credit_enq_sender #(
    .p1width(8), .p2depth(3), .p3cntr_width(2), .p4latency(2)
  ) dut (
    .CLK(clk), .RST(rst), .CLR(clr), .D_IN(d_in), .ENQ(enq),
    .FULL_N(full_n), .TX_VALID(tx_valid), .TX_DATA(tx_data),
    .CRED_RET(cred_ret), .CREDITS(credits), .IDLE(idle), .ERR(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every TX beat must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin
        tx_count++;
        if (sb.size() == 0) begin
          chk("unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("tx_data", {24'h0, tx_data}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; clr = 1'b0; enq = 1'b0; cred_ret = 1'b0; d_in = 8'h00;
    cyc(2);
    rst = 1'b0;

    // 1: reset state
    chk("rst_credits", credits, 3);
    chk("rst_full_n", full_n, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);

    // 2: fill all credits
    for (int i = 1; i <= 3; i++) begin
      enq = 1'b1; d_in = 8'(i); sb.push_back(8'(i));
      cyc();
    end
    enq = 1'b0;
    chk("fill_credits", credits, 0);
    chk("fill_full_n", full_n, 0);
    chk("fill_idle", idle, 0);
    cyc(3);
    chk("fill_drained", sb.size(), 0);
    chk("fill_tx_hold", tx_data, 8'h03);
    chk("fill_tx_valid_low", tx_valid, 0);

    // 3: enqueue without credit while a credit returns
    enq = 1'b1; d_in = 8'hAA; cred_ret = 1'b1;
    cyc();
    enq = 1'b0; cred_ret = 1'b0;
    chk("nocred_err", err, 1);
    chk("nocred_credits", credits, 1);
    chk("nocred_full_n", full_n, 1);
    cyc(3);
    cred_ret = 1'b1;
    cyc(2);
    cred_ret = 1'b0;
    chk("refill_credits", credits, 3);
    chk("refill_idle", idle, 1);
    chk("refill_err_sticky", err, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_err", err, 0);

    // 4: steady stream, credits looped back one cycle later
    base = tx_count;
    for (int i = 0; i < 12; i++) begin
      enq      = (i < 10);
      d_in     = 8'(8'h10 + i);
      cred_ret = (i >= 1 && i <= 10);
      if (i < 10) begin
        sb.push_back(8'(8'h10 + i));
        chk("stream_full_n", full_n, 1);
      end
      cyc();
    end
    enq = 1'b0; cred_ret = 1'b0;
    chk("stream_credits", credits, 3);
    cyc(2);
    chk("stream_tx_count", tx_count - base, 10);
    chk("stream_drained", sb.size(), 0);

    // 5: spurious credit return at full, then clear with entries in flight
    cred_ret = 1'b1;
    cyc();
    cred_ret = 1'b0;
    chk("sat_credits", credits, 3);
    chk("sat_err", err, 1);
    enq = 1'b1; d_in = 8'h21;
    cyc();
    chk("clrpre_credits", credits, 2);
    d_in = 8'h22; clr = 1'b1;
    cyc();
    enq = 1'b0; clr = 1'b0;
    chk("clr2_err", err, 0);
    chk("clr2_credits", credits, 3);
    chk("clr2_tx_valid", tx_valid, 0);
    base = tx_count;
    cyc(4);
    chk("clr2_no_tx", tx_count - base, 0);
    chk("clr2_idle", idle, 1);

    // 6: reset with entries in flight; the oldest reaches the output before reset
    enq = 1'b1; d_in = 8'h31; sb.push_back(8'h31);
    cyc();
    d_in = 8'h32;
    cyc();
    d_in = 8'h33; rst = 1'b1;
    cyc();
    enq = 1'b0; rst = 1'b0;
    chk("rst2_tx_valid", tx_valid, 0);
    chk("rst2_tx_data", tx_data, 0);
    chk("rst2_credits", credits, 3);
    chk("rst2_full_n", full_n, 1);
    chk("rst2_idle", idle, 1);
    base = tx_count;
    cyc(4);
    chk("rst2_no_tx", tx_count - base, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
